// File: rtl/ex_stage_if.sv
// ex_stage_if -- bundle between the decode stage and the execute stage.
//
// Signals (directions as seen by the execute stage):
//   valid_i      in   decode presents a valid instruction this cycle
//   alusel_i     in   operation class (000 logic, 001 shift, 010 arith, 011 multiply)
//   aluop_i      in   operation within the class
//   reg1_data_i  in   operand 1 (already forwarded)
//   reg2_data_i  in   operand 2 (register or zero-extended immediate)
//   wreg_i       in   instruction writes a destination register
//   waddr_i      in   destination register address
//   ex_we        out  registered result write enable
//   ex_waddr     out  registered result destination address
//   ex_wdata     out  registered result data
//   stall_o      out  combinational: decode must hold its outputs
//
// Modports: master = decode side, slave = execute stage.
interface ex_stage_if;
  logic        valid_i;
  logic [2:0]  alusel_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        stall_o;

  modport master (
    output valid_i, alusel_i, aluop_i, reg1_data_i, reg2_data_i, wreg_i, waddr_i,
    input  ex_we, ex_waddr, ex_wdata, stall_o
  );

  modport slave (
    input  valid_i, alusel_i, aluop_i, reg1_data_i, reg2_data_i, wreg_i, waddr_i,
    output ex_we, ex_waddr, ex_wdata, stall_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage -- pipeline execute stage.
//
// Single-cycle logic / shift / arithmetic operations are registered one edge
// after sampling. MULTU runs on a sequential shift-add multiplier: one partial
// product per cycle for 32 cycles, with stall_o holding decode until the
// result edge.
//
// Ports:
//   clk     in   clock, all state on its rising edge
//   reset   in   asynchronous, active-high reset
//   ex_bus  slave modport of ex_stage_if (instruction in, result/stall out)
module ex_stage (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  ex_bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] SEL_LOGIC = 3'b000;
  localparam logic [2:0] SEL_SHIFT = 3'b001;
  localparam logic [2:0] SEL_ARITH = 3'b010;
  localparam logic [2:0] SEL_MUL   = 3'b011;

  logic [0:0]  state_reg;
  logic [4:0]  count_reg;
  logic [31:0] mul_a_reg;
  logic [31:0] mul_b_reg;
  logic [31:0] acc_reg;
  logic [4:0]  mul_waddr_reg;
  logic        mul_wreg_reg;

  logic        ex_we_reg;
  logic [4:0]  ex_waddr_reg;
  logic [31:0] ex_wdata_reg;

  logic [31:0] op_result;
  logic        op_legal;
  logic        is_multu;
  logic [31:0] partial;
  logic [31:0] acc_next;

  // Operation decode for single-cycle classes; op_result stays 0 for illegal
  // pairs so the registered data is 0 without a separate mux.
  always_comb begin
    op_result = 32'd0;
    op_legal  = 1'b0;
    is_multu  = 1'b0;
    case (ex_bus.alusel_i)
      SEL_LOGIC: begin
        case (ex_bus.aluop_i)
          8'h0D: begin op_result = ex_bus.reg1_data_i | ex_bus.reg2_data_i;    op_legal = 1'b1; end
          8'h0C: begin op_result = ex_bus.reg1_data_i & ex_bus.reg2_data_i;    op_legal = 1'b1; end
          8'h0E: begin op_result = ex_bus.reg1_data_i ^ ex_bus.reg2_data_i;    op_legal = 1'b1; end
          8'h27: begin op_result = ~(ex_bus.reg1_data_i | ex_bus.reg2_data_i); op_legal = 1'b1; end
          default: ;
        endcase
      end
      SEL_SHIFT: begin
        case (ex_bus.aluop_i)
          8'h00: begin op_result = ex_bus.reg2_data_i << ex_bus.reg1_data_i[4:0]; op_legal = 1'b1; end
          8'h02: begin op_result = ex_bus.reg2_data_i >> ex_bus.reg1_data_i[4:0]; op_legal = 1'b1; end
          8'h03: begin
            op_result = $signed(ex_bus.reg2_data_i) >>> ex_bus.reg1_data_i[4:0];
            op_legal  = 1'b1;
          end
          default: ;
        endcase
      end
      SEL_ARITH: begin
        case (ex_bus.aluop_i)
          8'h21: begin op_result = ex_bus.reg1_data_i + ex_bus.reg2_data_i; op_legal = 1'b1; end
          8'h23: begin op_result = ex_bus.reg1_data_i - ex_bus.reg2_data_i; op_legal = 1'b1; end
          8'h2A: begin
            op_result = {31'd0, $signed(ex_bus.reg1_data_i) < $signed(ex_bus.reg2_data_i)};
            op_legal  = 1'b1;
          end
          default: ;
        endcase
      end
      SEL_MUL: begin
        if (ex_bus.aluop_i == 8'h19) begin
          is_multu = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One shift-add step: bit count_reg of the multiplier selects the
  // multiplicand shifted into place. Only the low 32 bits are kept.
  assign partial  = mul_b_reg[count_reg] ? (mul_a_reg << count_reg) : 32'd0;
  assign acc_next = acc_reg + partial;

  // Low in the final MUL cycle so decode advances on the result edge.
  assign ex_bus.stall_o = ~reset &
                          (((state_reg == ST_IDLE) & ex_bus.valid_i & is_multu) |
                           ((state_reg == ST_MUL) & (count_reg != 5'd31)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      count_reg     <= 5'd0;
      mul_a_reg     <= 32'd0;
      mul_b_reg     <= 32'd0;
      acc_reg       <= 32'd0;
      mul_waddr_reg <= 5'd0;
      mul_wreg_reg  <= 1'b0;
      ex_we_reg     <= 1'b0;
      ex_waddr_reg  <= 5'd0;
      ex_wdata_reg  <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ex_bus.valid_i) begin
            ex_waddr_reg <= ex_bus.waddr_i;
            if (is_multu) begin
              state_reg     <= ST_MUL;
              count_reg     <= 5'd0;
              acc_reg       <= 32'd0;
              mul_a_reg     <= ex_bus.reg1_data_i;
              mul_b_reg     <= ex_bus.reg2_data_i;
              mul_waddr_reg <= ex_bus.waddr_i;
              mul_wreg_reg  <= ex_bus.wreg_i;
              ex_we_reg     <= 1'b0;
              ex_wdata_reg  <= 32'd0;
            end else begin
              ex_we_reg    <= ex_bus.wreg_i & (ex_bus.waddr_i != 5'd0) & op_legal;
              ex_wdata_reg <= op_result;
            end
          end else begin
            ex_we_reg    <= 1'b0;
            ex_waddr_reg <= 5'd0;
            ex_wdata_reg <= 32'd0;
          end
        end
        default: begin // ST_MUL: bus inputs are ignored, only latched values count
          acc_reg      <= acc_next;
          count_reg    <= count_reg + 5'd1;
          ex_waddr_reg <= mul_waddr_reg;
          if (count_reg == 5'd31) begin
            state_reg    <= ST_IDLE;
            ex_we_reg    <= mul_wreg_reg & (mul_waddr_reg != 5'd0);
            ex_wdata_reg <= acc_next;
          end else begin
            ex_we_reg    <= 1'b0;
            ex_wdata_reg <= 32'd0;
          end
        end
      endcase
    end
  end

  assign ex_bus.ex_we    = ex_we_reg;
  assign ex_bus.ex_waddr = ex_waddr_reg;
  assign ex_bus.ex_wdata = ex_wdata_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- directed, table-driven bench for ex_stage.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .reset(reset), .ex_bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        wreg;
    logic [4:0]  waddr;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [7:0] op,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic wreg, input logic [4:0] waddr);
    bus.valid_i     = v;
    bus.alusel_i    = sel;
    bus.aluop_i     = op;
    bus.reg1_data_i = r1;
    bus.reg2_data_i = r2;
    bus.wreg_i      = wreg;
    bus.waddr_i     = waddr;
  endtask

  task automatic check_out(input string name, input logic we, input logic [4:0] waddr,
                           input logic [31:0] wdata);
    check({name, ".we"},    {31'd0, bus.ex_we},    {31'd0, we});
    check({name, ".waddr"}, {27'd0, bus.ex_waddr}, {27'd0, waddr});
    check({name, ".wdata"}, bus.ex_wdata,          wdata);
  endtask

  // Presents a MULTU and follows it to the result edge (33rd edge counting the
  // sampling edge as the first). Optionally disturbs the operands mid-flight.
  task automatic mul_run(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic wreg, input logic [4:0] waddr,
                         input logic exp_we, input logic [31:0] exp_data, input bit scramble);
    int stall_cycles = 0;
    int early_we     = 0;
    logic last_stall = 1'b0;
    drive(1'b1, 3'b011, 8'h19, a, b, wreg, waddr);
    #1;
    for (int e = 1; e <= 33; e++) begin
      if (bus.stall_o) stall_cycles++;
      last_stall = bus.stall_o;
      @(posedge clk);
      #1;
      if (e <= 32 && bus.ex_we) early_we++;
      if (scramble && e == 5) begin
        bus.reg1_data_i = 32'hDEADBEEF;
        bus.reg2_data_i = 32'h12345678;
        bus.waddr_i     = 5'd30;
        bus.wreg_i      = 1'b1;
      end
    end
    check({name, ".stall_cycles"}, stall_cycles, 32);
    check({name, ".stall_last"}, {31'd0, last_stall}, 32'd0);
    check({name, ".early_we"}, early_we, 0);
    check({name, ".we"}, {31'd0, bus.ex_we}, {31'd0, exp_we});
    if (exp_we) begin
      check({name, ".waddr"}, {27'd0, bus.ex_waddr}, {27'd0, waddr});
      check({name, ".wdata"}, bus.ex_wdata, exp_data);
    end
    $display("mul %s: stall_cycles=%0d we=%0d waddr=%0d wdata=%08h",
             name, stall_cycles, bus.ex_we, bus.ex_waddr, bus.ex_wdata);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stray_we;
    //          v     sel     op     r1            r2            wreg  wa    we    ewa   ewdata
    vecs[0]  = '{1'b1, 3'b000, 8'h0D, 32'h00001200, 32'h00000034, 1'b1, 5'd5, 1'b1, 5'd5, 32'h00001234}; // ORI
    vecs[1]  = '{1'b1, 3'b010, 8'h23, 32'h00000000, 32'h00000001, 1'b1, 5'd3, 1'b1, 5'd3, 32'hFFFFFFFF}; // SUBU 0-1
    vecs[2]  = '{1'b1, 3'b010, 8'h2A, 32'hFFFFFFFF, 32'h00000001, 1'b1, 5'd4, 1'b1, 5'd4, 32'h00000001}; // SLT -1<1
    vecs[3]  = '{1'b1, 3'b001, 8'h03, 32'h00000004, 32'h80000000, 1'b1, 5'd6, 1'b1, 5'd6, 32'hF8000000}; // SRA
    vecs[4]  = '{1'b1, 3'b001, 8'h00, 32'h00000008, 32'h000000FF, 1'b1, 5'd7, 1'b1, 5'd7, 32'h0000FF00}; // SLL
    vecs[5]  = '{1'b1, 3'b001, 8'h02, 32'h00000004, 32'h80000000, 1'b1, 5'd8, 1'b1, 5'd8, 32'h08000000}; // SRL
    vecs[6]  = '{1'b1, 3'b000, 8'h0C, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd9, 1'b1, 5'd9, 32'hF000F000}; // AND
    vecs[7]  = '{1'b1, 3'b000, 8'h0E, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd10, 1'b1, 5'd10, 32'h0FF00FF0}; // XOR
    vecs[8]  = '{1'b1, 3'b000, 8'h27, 32'h0000FFFF, 32'h00FF0000, 1'b1, 5'd11, 1'b1, 5'd11, 32'hFF000000}; // NOR
    vecs[9]  = '{1'b1, 3'b010, 8'h21, 32'hFFFFFFFF, 32'h00000002, 1'b1, 5'd12, 1'b1, 5'd12, 32'h00000001}; // ADDU wrap
    vecs[10] = '{1'b1, 3'b010, 8'h2A, 32'h00000001, 32'hFFFFFFFF, 1'b1, 5'd13, 1'b1, 5'd13, 32'h00000000}; // SLT 1<-1
    vecs[11] = '{1'b1, 3'b010, 8'h21, 32'h00000002, 32'h00000003, 1'b1, 5'd0, 1'b0, 5'd0, 32'h00000005}; // waddr 0
    vecs[12] = '{1'b1, 3'b010, 8'h21, 32'h00000002, 32'h00000003, 1'b0, 5'd9, 1'b0, 5'd9, 32'h00000005}; // wreg 0
    vecs[13] = '{1'b1, 3'b000, 8'hFF, 32'h12345678, 32'h9ABCDEF0, 1'b1, 5'd5, 1'b0, 5'd5, 32'h00000000}; // bad aluop
    vecs[14] = '{1'b1, 3'b100, 8'h21, 32'h00000002, 32'h00000003, 1'b1, 5'd14, 1'b0, 5'd14, 32'h00000000}; // bad alusel
    vecs[15] = '{1'b0, 3'b010, 8'h21, 32'h00000002, 32'h00000003, 1'b1, 5'd15, 1'b0, 5'd0, 32'h00000000}; // valid 0
    vecs[16] = '{1'b1, 3'b011, 8'h21, 32'h00000002, 32'h00000003, 1'b1, 5'd16, 1'b0, 5'd16, 32'h00000000}; // bad mul op

    // Reset with a MULTU presented: stall must stay low, outputs zero.
    reset = 1'b1;
    drive(1'b1, 3'b011, 8'h19, 32'h00010003, 32'h00000005, 1'b1, 5'd7);
    #1;
    check("reset.stall", {31'd0, bus.stall_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 5'd0, 32'd0);
    check("reset.stall2", {31'd0, bus.stall_o}, 32'd0);
    $display("reset: we=%0d waddr=%0d wdata=%08h stall=%0d",
             bus.ex_we, bus.ex_waddr, bus.ex_wdata, bus.stall_o);

    // Table vectors, first one taken on the first edge after release.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].sel, vecs[i].op, vecs[i].r1, vecs[i].r2,
            vecs[i].wreg, vecs[i].waddr);
      #1;
      check($sformatf("vec%0d.stall", i), {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_waddr, vecs[i].exp_wdata);
      $display("vec %0d: we=%0d waddr=%0d wdata=%08h", i, bus.ex_we, bus.ex_waddr, bus.ex_wdata);
    end

    // Multiply: reference case with mid-flight operand disturbance, then
    // wrap-around product and the two write-suppression cases.
    mul_run("mul_ref",  32'h00010003, 32'h00000005, 1'b1, 5'd7,  1'b1, 32'h0005000F, 1'b1);
    mul_run("mul_wrap", 32'hFFFFFFFF, 32'h00000003, 1'b1, 5'd12, 1'b1, 32'hFFFFFFFD, 1'b0);
    mul_run("mul_wa0",  32'h00000007, 32'h00000006, 1'b1, 5'd0,  1'b0, 32'h0000002A, 1'b0);
    mul_run("mul_wr0",  32'h00000007, 32'h00000006, 1'b0, 5'd9,  1'b0, 32'h0000002A, 1'b0);

    // Reset while counter==10 aborts the multiply.
    drive(1'b1, 3'b011, 8'h19, 32'h00010003, 32'h00000005, 1'b1, 5'd7);
    repeat (11) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_out("abort", 1'b0, 5'd0, 32'd0);
    check("abort.stall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check("abort.stall_hold", {31'd0, bus.stall_o}, 32'd0);
    $display("abort: we=%0d waddr=%0d wdata=%08h stall=%0d",
             bus.ex_we, bus.ex_waddr, bus.ex_wdata, bus.stall_o);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'b010, 8'h21, 32'd2, 32'd3, 1'b1, 5'd8);
    @(posedge clk);
    #1;
    check_out("post_reset_addu", 1'b1, 5'd8, 32'd5);
    $display("post_reset_addu: we=%0d waddr=%0d wdata=%08h", bus.ex_we, bus.ex_waddr, bus.ex_wdata);
    drive(1'b0, 3'b000, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
    stray_we = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ex_we) stray_we++;
    end
    check("abort.no_write", stray_we, 0);

    // Back-to-back ADDU, XOR, MULTU, OR.
    drive(1'b1, 3'b010, 8'h21, 32'd10, 32'd20, 1'b1, 5'd1);
    @(posedge clk);
    #1;
    check_out("b2b_addu", 1'b1, 5'd1, 32'd30);
    $display("b2b_addu: we=%0d waddr=%0d wdata=%08h", bus.ex_we, bus.ex_waddr, bus.ex_wdata);
    drive(1'b1, 3'b000, 8'h0E, 32'hAAAA5555, 32'hFFFF0000, 1'b1, 5'd2);
    @(posedge clk);
    #1;
    check_out("b2b_xor", 1'b1, 5'd2, 32'h55555555);
    $display("b2b_xor: we=%0d waddr=%0d wdata=%08h", bus.ex_we, bus.ex_waddr, bus.ex_wdata);
    mul_run("b2b_mul", 32'h00000100, 32'h00000100, 1'b1, 5'd3, 1'b1, 32'h00010000, 1'b0);
    drive(1'b1, 3'b000, 8'h0D, 32'h00F00000, 32'h0000000F, 1'b1, 5'd4);
    #1;
    check("b2b_or.stall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk);
    #1;
    check_out("b2b_or", 1'b1, 5'd4, 32'h00F0000F);
    $display("b2b_or: we=%0d waddr=%0d wdata=%08h", bus.ex_we, bus.ex_waddr, bus.ex_wdata);
    drive(1'b0, 3'b000, 8'h00, 32'd0, 32'd0, 1'b0, 5'd0);
    @(posedge clk);
    #1;
    check_out("idle", 1'b0, 5'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
